// File: rtl/mcpu_ctrl.sv
// mcpu_ctrl -- multi-cycle MIPS control unit.
// Moore FSM that sequences a shared datapath (PC, IR, register file,
// immediate extender, ALU, unified memory) and waits on mem_ready for every
// memory access. All control outputs are forced low while rst_n is low.
// Optional build macro: MCPU_ZEXT_EN adds andi/ori (zero-extended immediate).
module mcpu_ctrl #(
  parameter int ST_W  = 4,
  parameter int ALU_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       op,
  input  logic [5:0]       func,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             iord,
  output logic             mem_r,
  output logic             mem_w,
  output logic             ir_write,
  output logic             reg_write,
  output logic [1:0]       reg_dst,
  output logic [1:0]       mem2reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [ALU_W-1:0] alu_ctrl,
  output logic [1:0]       pc_source,
  output logic             ext_zero,
  output logic             illegal,
  output logic [ST_W-1:0]  state
);

  typedef enum logic [ST_W-1:0] {
    S_IF  = ST_W'(0),  S_ID  = ST_W'(1),  S_MA  = ST_W'(2),  S_MR  = ST_W'(3),
    S_LWB = ST_W'(4),  S_MW  = ST_W'(5),  S_RX  = ST_W'(6),  S_RWB = ST_W'(7),
    S_BEQ = ST_W'(8),  S_JMP = ST_W'(9),  S_IX  = ST_W'(10), S_IWB = ST_W'(11)
  } state_t;

  typedef struct packed {
    logic             pc_write;
    logic             pc_write_cond;
    logic             iord;
    logic             mem_r;
    logic             mem_w;
    logic             ir_write;
    logic             reg_write;
    logic [1:0]       reg_dst;
    logic [1:0]       mem2reg;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [ALU_W-1:0] alu_ctrl;
    logic [1:0]       pc_source;
    logic             ext_zero;
    logic             illegal;
  } ctrl_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  localparam logic [ALU_W-1:0] ALU_ADD = ALU_W'(3'b010);
  localparam logic [ALU_W-1:0] ALU_SUB = ALU_W'(3'b110);
  localparam logic [ALU_W-1:0] ALU_AND = ALU_W'(3'b000);
  localparam logic [ALU_W-1:0] ALU_OR  = ALU_W'(3'b001);
  localparam logic [ALU_W-1:0] ALU_SLT = ALU_W'(3'b111);
  localparam logic [ALU_W-1:0] ALU_NOR = ALU_W'(3'b100);

  state_t state_q, state_d;
  ctrl_t  ctrl;
  logic             func_ok;
  logic [ALU_W-1:0] func_alu;

  // Map R-type funct to an ALU operation and flag unsupported functs.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    func_ok  = 1'b1;
    func_alu = ALU_ADD;
    case (func)
      6'b100000: func_alu = ALU_ADD;
      6'b100010: func_alu = ALU_SUB;
      6'b100100: func_alu = ALU_AND;
      6'b100101: func_alu = ALU_OR;
      6'b101010: func_alu = ALU_SLT;
      6'b100111: func_alu = ALU_NOR;
      default:   func_ok  = 1'b0;
    endcase
  end

  // State register; reset returns to instruction fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state updates use non-blocking assignment so every flop samples
    // values from before the edge.
    if (!rst_n) state_q <= S_IF;
    else        state_q <= state_d;
  end

  // Next-state and Moore control decode.
  always_comb begin
    state_d = state_q;
    ctrl    = '0;
    case (state_q)
      S_IF: begin
        ctrl.mem_r     = 1'b1;
        ctrl.alu_src_b = 2'b01;
        ctrl.alu_ctrl  = ALU_ADD;
        // PC+4 and IR load commit only in the cycle memory returns the word.
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
        if (mem_ready) state_d = S_ID;
      end
      S_ID: begin
        // Branch target PC + (imm<<2) is computed speculatively here.
        ctrl.alu_src_b = 2'b11;
        ctrl.alu_ctrl  = ALU_ADD;
        case (op)
          OP_RTYPE:      state_d = func_ok ? S_RX : S_IF;
          OP_LW, OP_SW:  state_d = S_MA;
          OP_BEQ:        state_d = S_BEQ;
          OP_J:          state_d = S_JMP;
          OP_ADDI,
          OP_SLTI:       state_d = S_IX;
`ifdef MCPU_ZEXT_EN
          OP_ANDI,
          OP_ORI:        state_d = S_IX;
`endif
          default:       state_d = S_IF;
        endcase
        ctrl.illegal = (state_d == S_IF);
      end
      S_MA: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
        ctrl.alu_ctrl  = ALU_ADD;
        state_d        = (op == OP_SW) ? S_MW : S_MR;
      end
      S_MR: begin
        ctrl.mem_r = 1'b1;
        ctrl.iord  = 1'b1;
        if (mem_ready) state_d = S_LWB;
      end
      S_LWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 2'b00;
        ctrl.mem2reg   = 2'b01;
        state_d        = S_IF;
      end
      S_MW: begin
        ctrl.mem_w = 1'b1;
        ctrl.iord  = 1'b1;
        if (mem_ready) state_d = S_IF;
      end
      S_RX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b00;
        ctrl.alu_ctrl  = func_alu;
        state_d        = S_RWB;
      end
      S_RWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 2'b01;
        state_d        = S_IF;
      end
      S_BEQ: begin
        // The PC load itself is qualified by zero in the datapath.
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = 2'b00;
        ctrl.alu_ctrl      = ALU_SUB;
        ctrl.pc_source     = 2'b01;
        ctrl.pc_write_cond = 1'b1;
        state_d            = S_IF;
      end
      S_JMP: begin
        ctrl.pc_source = 2'b10;
        ctrl.pc_write  = 1'b1;
        state_d        = S_IF;
      end
      S_IX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
        ctrl.alu_ctrl  = (op == OP_SLTI) ? ALU_SLT : ALU_ADD;
`ifdef MCPU_ZEXT_EN
        // Logical immediates zero-extend; addi/slti keep sign extension.
        if (op == OP_ANDI) begin
          ctrl.alu_ctrl = ALU_AND;
          ctrl.ext_zero = 1'b1;
        end else if (op == OP_ORI) begin
          ctrl.alu_ctrl = ALU_OR;
          ctrl.ext_zero = 1'b1;
        end
`endif
        state_d = S_IWB;
      end
      S_IWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 2'b00;
        state_d        = S_IF;
      end
      default: state_d = S_IF;
    endcase
  end

  // Reset gates every control output combinationally so strobes and write
  // enables drop the instant rst_n falls, not at the next clock.
  ctrl_t ctrl_out;
  assign ctrl_out = rst_n ? ctrl : '0;

  assign pc_write      = ctrl_out.pc_write;
  assign pc_write_cond = ctrl_out.pc_write_cond;
  assign iord          = ctrl_out.iord;
  assign mem_r         = ctrl_out.mem_r;
  assign mem_w         = ctrl_out.mem_w;
  assign ir_write      = ctrl_out.ir_write;
  assign reg_write     = ctrl_out.reg_write;
  assign reg_dst       = ctrl_out.reg_dst;
  assign mem2reg       = ctrl_out.mem2reg;
  assign alu_src_a     = ctrl_out.alu_src_a;
  assign alu_src_b     = ctrl_out.alu_src_b;
  assign alu_ctrl      = ctrl_out.alu_ctrl;
  assign pc_source     = ctrl_out.pc_source;
  assign ext_zero      = ctrl_out.ext_zero;
  assign illegal       = ctrl_out.illegal;
  assign state         = state_q;

  // zero is consumed by the datapath's PC-load qualifier, not by the FSM.
  logic unused_zero;
  assign unused_zero = zero;

endmodule

// File: tb/tb_mcpu_ctrl.sv
// tb_mcpu_ctrl -- self-checking bench for mcpu_ctrl.
// Instruction vectors list the expected state walk; a reference decode of
// the control table produces expected outputs per cycle, queued when the
// cycle's inputs are driven and compared at the following falling edge.
module tb_mcpu_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] op, func;
  logic       zero, mem_ready;
  logic       pc_write, pc_write_cond, iord, mem_r, mem_w, ir_write, reg_write;
  logic [1:0] reg_dst, mem2reg, alu_src_b, pc_source;
  logic       alu_src_a, ext_zero, illegal;
  logic [2:0] alu_ctrl;
  logic [3:0] state;

  always #5 clk = ~clk;

  mcpu_ctrl dut (
    .clk(clk), .rst_n(rst_n), .op(op), .func(func), .zero(zero),
    .mem_ready(mem_ready), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .iord(iord), .mem_r(mem_r), .mem_w(mem_w), .ir_write(ir_write),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem2reg(mem2reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl),
    .pc_source(pc_source), .ext_zero(ext_zero), .illegal(illegal),
    .state(state)
  );

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_r;
    logic       mem_w;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem2reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_ctrl;
    logic [1:0] pc_source;
    logic       ext_zero;
    logic       illegal;
    logic [3:0] state;
  } out_t;

  // seq holds up to 12 expected states, first state in the top nibble.
  typedef struct {
    string      name;
    logic [5:0] op;
    logic [5:0] func;
    logic       zero;
    int         if_waits;
    int         mem_waits;
    int         len;
    logic [47:0] seq;
  } vec_t;

  vec_t vecs[$];
  out_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  function automatic out_t sample();
    return {pc_write, pc_write_cond, iord, mem_r, mem_w, ir_write, reg_write,
            reg_dst, mem2reg, alu_src_a, alu_src_b, alu_ctrl, pc_source,
            ext_zero, illegal, state};
  endfunction

  function automatic logic decodable(logic [5:0] o, logic [5:0] f);
    case (o)
      6'h00: return f inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h27};
      6'h23, 6'h2b, 6'h04, 6'h02, 6'h08, 6'h0a: return 1'b1;
`ifdef MCPU_ZEXT_EN
      6'h0c, 6'h0d: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  // Reference control table, written from the instruction-set view.
  function automatic out_t ref_out(logic [3:0] s, logic [5:0] o,
                                   logic [5:0] f, logic mr);
    out_t r = '0;
    r.state = s;
    case (s)
      4'd0:  begin r.mem_r = 1; r.alu_src_b = 2'b01; r.alu_ctrl = 3'b010;
                   r.ir_write = mr; r.pc_write = mr; end
      4'd1:  begin r.alu_src_b = 2'b11; r.alu_ctrl = 3'b010;
                   r.illegal = !decodable(o, f); end
      4'd2:  begin r.alu_src_a = 1; r.alu_src_b = 2'b10; r.alu_ctrl = 3'b010; end
      4'd3:  begin r.mem_r = 1; r.iord = 1; end
      4'd4:  begin r.reg_write = 1; r.mem2reg = 2'b01; end
      4'd5:  begin r.mem_w = 1; r.iord = 1; end
      4'd6:  begin
               r.alu_src_a = 1;
               case (f)
                 6'h20: r.alu_ctrl = 3'b010;
                 6'h22: r.alu_ctrl = 3'b110;
                 6'h24: r.alu_ctrl = 3'b000;
                 6'h25: r.alu_ctrl = 3'b001;
                 6'h2a: r.alu_ctrl = 3'b111;
                 default: r.alu_ctrl = 3'b100;
               endcase
             end
      4'd7:  begin r.reg_write = 1; r.reg_dst = 2'b01; end
      4'd8:  begin r.alu_src_a = 1; r.alu_ctrl = 3'b110; r.pc_source = 2'b01;
                   r.pc_write_cond = 1; end
      4'd9:  begin r.pc_source = 2'b10; r.pc_write = 1; end
      4'd10: begin
               r.alu_src_a = 1; r.alu_src_b = 2'b10;
               case (o)
                 6'h0a: r.alu_ctrl = 3'b111;
                 6'h0c: begin r.alu_ctrl = 3'b000; r.ext_zero = 1; end
                 6'h0d: begin r.alu_ctrl = 3'b001; r.ext_zero = 1; end
                 default: r.alu_ctrl = 3'b010;
               endcase
             end
      4'd11: r.reg_write = 1;
      default: ;
    endcase
    return r;
  endfunction

  task automatic check(string name, out_t got, out_t exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Drives one instruction, entering and leaving at posedge+1.
  task automatic run_vec(vec_t v);
    int iw = v.if_waits;
    int mw = v.mem_waits;
    op = v.op; func = v.func; zero = v.zero;
    for (int i = 0; i < v.len; i++) begin
      logic [3:0] s = v.seq[47-4*i -: 4];
      if (s == 4'd0) begin
        mem_ready = (iw == 0); if (iw > 0) iw--;
      end else if (s == 4'd3 || s == 4'd5) begin
        mem_ready = (mw == 0); if (mw > 0) mw--;
      end else begin
        mem_ready = 1'($urandom_range(0, 1));
      end
      exp_q.push_back(ref_out(s, v.op, v.func, mem_ready));
      @(negedge clk);
      if (exp_q.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL %s: scoreboard empty", v.name);
      end else begin
        check($sformatf("%s[%0d]", v.name, i), sample(), exp_q.pop_front());
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst_n = 1'b0; op = '0; func = '0; zero = 1'b0; mem_ready = 1'b0;

    //          name      op     func   z  ifw mw len seq
    vecs.push_back('{"add",    6'h00, 6'h20, 0, 0, 0, 4, 48'h0167_0000_0000});
    vecs.push_back('{"sub",    6'h00, 6'h22, 0, 0, 0, 4, 48'h0167_0000_0000});
    vecs.push_back('{"and",    6'h00, 6'h24, 0, 0, 0, 4, 48'h0167_0000_0000});
    vecs.push_back('{"or",     6'h00, 6'h25, 0, 0, 0, 4, 48'h0167_0000_0000});
    vecs.push_back('{"slt",    6'h00, 6'h2a, 0, 0, 0, 4, 48'h0167_0000_0000});
    vecs.push_back('{"nor",    6'h00, 6'h27, 0, 0, 0, 4, 48'h0167_0000_0000});
    vecs.push_back('{"add_ifw",6'h00, 6'h20, 0, 2, 0, 6, 48'h0001_6700_0000});
    vecs.push_back('{"lw",     6'h23, 6'h00, 0, 0, 0, 5, 48'h0123_4000_0000});
    vecs.push_back('{"lw_w3",  6'h23, 6'h11, 0, 0, 3, 8, 48'h0123_3334_0000});
    vecs.push_back('{"sw",     6'h2b, 6'h00, 0, 0, 0, 4, 48'h0125_0000_0000});
    vecs.push_back('{"sw_w2",  6'h2b, 6'h00, 0, 0, 2, 6, 48'h0125_5500_0000});
    vecs.push_back('{"beq_z1", 6'h04, 6'h00, 1, 0, 0, 3, 48'h0180_0000_0000});
    vecs.push_back('{"beq_z0", 6'h04, 6'h00, 0, 0, 0, 3, 48'h0180_0000_0000});
    vecs.push_back('{"j",      6'h02, 6'h00, 0, 0, 0, 3, 48'h0190_0000_0000});
    vecs.push_back('{"addi",   6'h08, 6'h3f, 0, 0, 0, 4, 48'h01ab_0000_0000});
    vecs.push_back('{"slti",   6'h0a, 6'h00, 0, 0, 0, 4, 48'h01ab_0000_0000});
    vecs.push_back('{"op3f",   6'h3f, 6'h20, 0, 0, 0, 2, 48'h0100_0000_0000});
    vecs.push_back('{"rbadfn", 6'h00, 6'h00, 0, 0, 0, 2, 48'h0100_0000_0000});
`ifdef MCPU_ZEXT_EN
    vecs.push_back('{"andi",   6'h0c, 6'h00, 0, 0, 0, 4, 48'h01ab_0000_0000});
    vecs.push_back('{"ori",    6'h0d, 6'h00, 0, 0, 0, 4, 48'h01ab_0000_0000});
`else
    vecs.push_back('{"andi",   6'h0c, 6'h00, 0, 0, 0, 2, 48'h0100_0000_0000});
    vecs.push_back('{"ori",    6'h0d, 6'h00, 0, 0, 0, 2, 48'h0100_0000_0000});
`endif

    // Held in reset: everything low, state IF.
    repeat (2) @(posedge clk);
    #1 check("reset_hold", sample(), '0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("after_release", sample(), ref_out(4'd0, op, func, 1'b0));
    @(posedge clk); #1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset asserted while lw waits in MR: outputs drop at once.
    run_vec('{"lw_pre_rst", 6'h23, 6'h00, 0, 0, 9, 4, 48'h0123_0000_0000});
    #2 rst_n = 1'b0;
    #1 check("mid_mr_reset", sample(), '0);
    @(negedge clk);
    mem_ready = 1'b0;
    rst_n = 1'b1;
    #1 check("mr_release", sample(), ref_out(4'd0, 6'h23, 6'h00, 1'b0));
    @(posedge clk); #1;
    run_vec('{"j_post_rst", 6'h02, 6'h00, 0, 0, 0, 3, 48'h0190_0000_0000});

    // Reset asserted while sw waits in MW: write strobe drops at once.
    run_vec('{"sw_pre_rst", 6'h2b, 6'h00, 0, 0, 9, 4, 48'h0125_0000_0000});
    #2 rst_n = 1'b0;
    #1 check("mid_mw_reset", sample(), '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_vec('{"add_post", 6'h00, 6'h20, 0, 1, 0, 5, 48'h0016_7000_0000});

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mcpu_ctrl.md
Name: mcpu_ctrl

Overview:
- Multi-cycle MIPS control unit.
- Sequences the shared datapath: PC, IR, register file, immediate extender, ALU, and unified memory.
- Decodes opcode/funct, steps a Moore FSM, and handshakes with memory via mem_ready.
- Drives the extender mode select (sign vs zero) for the 16-to-32-bit immediate path.

Parameters:
- ST_W, 4, state register width.
- ALU_W, 3, alu_ctrl width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- op  in  6  IR[31:26].
- func  in  6  IR[5:0].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory done for the current access.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load if zero.
- iord  out  1  memory address select: 0=PC, 1=ALUOut.
- mem_r  out  1  memory read strobe.
- mem_w  out  1  memory write strobe.
- ir_write  out  1  IR load.
- reg_write  out  1  register file write enable.
- reg_dst  out  2  write register select: 00=rt, 01=rd.
- mem2reg  out  2  write data select: 00=ALUOut, 01=MDR.
- alu_src_a  out  1  ALU A select: 0=PC, 1=A reg.
- alu_src_b  out  2  ALU B select: 00=B, 01=4, 10=imm32, 11=imm32<<2.
- alu_ctrl  out  3  ALU operation: 010 add, 110 sub, 000 and, 001 or, 111 slt, 100 nor.
- pc_source  out  2  PC source: 00=ALU result, 01=ALUOut, 10=jump address.
- ext_zero  out  1  extender mode: 1=zero-extend, 0=sign-extend.
- illegal  out  1  one-cycle pulse on undecodable instruction.
- state  out  4  current state, for debug.

Behaviour:
- Reset: rst_n low asynchronously forces state=IF. All control outputs read 0 while rst_n=0, combinationally gated. First fetch starts on the first clk edge after release.
- Reset mid-operation: any pending memory strobe drops immediately; no PC, IR, or register write occurs.
- Output model: Moore, decoded from state. Unlisted outputs are 0 in each state.
- State encodings: IF=0, ID=1, MA=2, MR=3, LWB=4, MW=5, RX=6, RWB=7, BEQ=8, JMP=9, IX=10, IWB=11.
- IF: mem_r=1, alu_src_b=01, alu_ctrl=add.
  - ir_write=pc_write=mem_ready.
  - Stay in IF while mem_ready=0; go to ID on mem_ready=1.
- ID: alu_src_b=11, alu_ctrl=add (precomputes branch target). Next state by op:
  - 000000 -> RX
  - 100011 / 101011 -> MA
  - 000100 -> BEQ
  - 000010 -> JMP
  - 001000 (addi) / 001010 (slti) -> IX
  - else -> illegal=1 for this cycle, then IF
  - R-type with func outside {100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt, 100111 nor} -> illegal, then IF.
- MA: alu_src_a=1, alu_src_b=10, add. lw -> MR, sw -> MW.
- MR: mem_r=1, iord=1. Wait for mem_ready, then LWB.
- LWB: reg_write=1, reg_dst=00, mem2reg=01. Next IF.
- MW: mem_w=1, iord=1. Wait for mem_ready, then IF.
- RX: alu_src_a=1, alu_src_b=00, alu_ctrl from func. Next RWB.
- RWB: reg_write=1, reg_dst=01. Next IF.
- BEQ: alu_src_a=1, alu_src_b=00, sub, pc_source=01, pc_write_cond=1. Next IF.
- JMP: pc_source=10, pc_write=1. Next IF.
- IX: alu_src_a=1, alu_src_b=10. alu_ctrl = add for addi, slt for slti. Next IWB.
- IWB: reg_write=1, reg_dst=00. Next IF.
- ext_zero is 0 everywhere unless MCPU_ZEXT_EN applies.
- Latency (mem_ready asserted on first request): R=4, addi=4, lw=5, sw=4, beq=3, j=3 cycles. Each wait cycle adds 1.
- mem_ready outside IF/MR/MW: ignored.
- Strobes held stable: mem_r/mem_w stay constant for the entire wait.

Optional Feature:
- MCPU_ZEXT_EN defined:
  - andi (001100) and ori (001101) decode to IX.
  - alu_ctrl = and / or respectively.
  - ext_zero=1 in IX.
- Undefined:
  - andi/ori are illegal.
  - ext_zero is tied 0.

Test Plan:
- Reset with rst_n=0 mid-MR -> all outputs 0 at once, state=0. After release, IF asserts mem_r=1 with alu_src_b=01.
- R-type add (op=0, func=100000), mem_ready=1 always -> states 0,1,6,7,0. reg_write=1 and reg_dst=01 only in state 7. alu_ctrl=010 in state 6.
- lw with mem_ready held low for 3 cycles in MR -> stays in MR 4 cycles with mem_r=1, iord=1, then LWB with mem2reg=01. Total 8 cycles.
- beq with zero=1 vs zero=0 -> pc_write_cond=1 and pc_source=01 in state 8 in both cases. Returns to IF after 3 cycles.
- op=111111 -> illegal=1 for exactly one cycle in ID, then IF. No reg_write or mem_w asserted.
- ori (001101) -> with MCPU_ZEXT_EN: IX with ext_zero=1, alu_ctrl=001. Without: illegal pulse.
